// File: rtl/id_ex_stage.sv
// ID/EX boundary: decodes the ID instruction into control + ALU op, registers it with operands,
// inserts bubbles on load-use hazards; 1-cycle latency, stallOut holds IF/ID, EX always advances.
module id_ex_stage #(
    parameter int DATA_W    = 32,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 idValid,
    input  logic [31:0]          idInstr,
    input  logic [DATA_W-1:0]    idReadData1,
    input  logic [DATA_W-1:0]    idReadData2,
    input  logic                 flush,
    output logic                 stallOut,
    output logic                 exValid,
    output logic [3:0]           exAluOp,
    output logic                 exRegWrite,
    output logic                 exMemRead,
    output logic                 exMemWrite,
    output logic                 exAluSrc,
    output logic                 exRegDst,
    output logic                 exMemToReg,
    output logic                 exBranch,
    output logic [DATA_W-1:0]    exReadData1,
    output logic [DATA_W-1:0]    exReadData2,
    output logic [DATA_W-1:0]    exImm,
    output logic [4:0]           exRs,
    output logic [4:0]           exRt,
    output logic [4:0]           exRd,
    output logic [4:0]           exShamt,
    output logic [ILL_CNT_W-1:0] illegalCount
);

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_NOR  = 4'h5;
    localparam logic [3:0] ALU_SLT  = 4'h6;
    localparam logic [3:0] ALU_SLL  = 4'h7;
    localparam logic [3:0] ALU_SRL  = 4'h8;
    localparam logic [3:0] ALU_SRA  = 4'h9;
    localparam logic [3:0] ALU_LUI  = 4'hA;
    localparam logic [3:0] ALU_SLTU = 4'hB;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;

    assign opcode = idInstr[31:26];
    assign funct  = idInstr[5:0];
    assign rs     = idInstr[25:21];
    assign rt     = idInstr[20:16];
    assign imm    = idInstr[15:0];

    logic [3:0] dec_alu_op;
    logic dec_reg_write, dec_mem_read, dec_mem_write, dec_alu_src;
    logic dec_reg_dst, dec_mem_to_reg, dec_branch;
    logic dec_legal, dec_zext, uses_rt;

    always_comb begin
        dec_alu_op     = ALU_ADD;
        dec_reg_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_alu_src    = 1'b0;
        dec_reg_dst    = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_branch     = 1'b0;
        dec_legal      = 1'b1;
        dec_zext       = 1'b0;
        uses_rt        = 1'b0;
        case (opcode)
            6'h00: begin
                dec_reg_dst   = 1'b1;
                dec_reg_write = 1'b1;
                uses_rt       = 1'b1;
                case (funct)
                    6'h20, 6'h21: dec_alu_op = ALU_ADD;
                    6'h22, 6'h23: dec_alu_op = ALU_SUB;
                    6'h24:        dec_alu_op = ALU_AND;
                    6'h25:        dec_alu_op = ALU_OR;
                    6'h26:        dec_alu_op = ALU_XOR;
                    6'h27:        dec_alu_op = ALU_NOR;
                    6'h2A:        dec_alu_op = ALU_SLT;
                    6'h2B:        dec_alu_op = ALU_SLTU;
                    6'h00:        dec_alu_op = ALU_SLL;
                    6'h02:        dec_alu_op = ALU_SRL;
                    6'h03:        dec_alu_op = ALU_SRA;
                    default:      dec_legal  = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin dec_alu_op = ALU_ADD;  dec_alu_src = 1'b1; dec_reg_write = 1'b1; end
            6'h0C: begin dec_alu_op = ALU_AND;  dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_zext = 1'b1; end
            6'h0D: begin dec_alu_op = ALU_OR;   dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_zext = 1'b1; end
            6'h0E: begin dec_alu_op = ALU_XOR;  dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_zext = 1'b1; end
            6'h0A: begin dec_alu_op = ALU_SLT;  dec_alu_src = 1'b1; dec_reg_write = 1'b1; end
            6'h0B: begin dec_alu_op = ALU_SLTU; dec_alu_src = 1'b1; dec_reg_write = 1'b1; end
            6'h0F: begin dec_alu_op = ALU_LUI;  dec_alu_src = 1'b1; dec_reg_write = 1'b1; end
            6'h23: begin
                dec_alu_op     = ALU_ADD;
                dec_alu_src    = 1'b1;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_reg_write  = 1'b1;
            end
            6'h2B: begin dec_alu_op = ALU_ADD; dec_alu_src = 1'b1; dec_mem_write = 1'b1; uses_rt = 1'b1; end
            6'h04, 6'h05: begin dec_alu_op = ALU_SUB; dec_branch = 1'b1; uses_rt = 1'b1; end
            default: dec_legal = 1'b0;
        endcase
    end

    logic                 valid_q, valid_d;
    logic [3:0]           alu_op_q, alu_op_d;
    logic                 reg_write_q, reg_write_d, mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d, alu_src_q, alu_src_d;
    logic                 reg_dst_q, reg_dst_d, mem_to_reg_q, mem_to_reg_d;
    logic                 branch_q, branch_d;
    logic [DATA_W-1:0]    rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [4:0]           rs_q, rs_d, rt_q, rt_d, rd_q, rd_d, shamt_q, shamt_d;
    logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;

    logic hazard, load_en, ill_inc;

    // rs is always read; rt only matters when the ID instruction actually consumes it.
    assign hazard = valid_q & mem_read_q & (rt_q != 5'd0) & idValid &
                    ((rt_q == rs) | (uses_rt & (rt_q == rt)));
    assign stallOut = hazard & ~flush;
    assign load_en  = ~flush & ~hazard & idValid & dec_legal;
    assign ill_inc  = ~flush & ~hazard & idValid & ~dec_legal;

    always_comb begin
        valid_d      = 1'b0;
        alu_op_d     = 4'h0;
        reg_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        alu_src_d    = 1'b0;
        reg_dst_d    = 1'b0;
        mem_to_reg_d = 1'b0;
        branch_d     = 1'b0;
        rd1_d        = '0;
        rd2_d        = '0;
        imm_d        = '0;
        rs_d         = 5'd0;
        rt_d         = 5'd0;
        rd_d         = 5'd0;
        shamt_d      = 5'd0;
        if (load_en) begin
            valid_d      = 1'b1;
            alu_op_d     = dec_alu_op;
            reg_write_d  = dec_reg_write;
            mem_read_d   = dec_mem_read;
            mem_write_d  = dec_mem_write;
            alu_src_d    = dec_alu_src;
            reg_dst_d    = dec_reg_dst;
            mem_to_reg_d = dec_mem_to_reg;
            branch_d     = dec_branch;
            rd1_d        = idReadData1;
            rd2_d        = idReadData2;
            imm_d        = dec_zext ? {{(DATA_W-16){1'b0}}, imm} : {{(DATA_W-16){imm[15]}}, imm};
            rs_d         = rs;
            rt_d         = rt;
            rd_d         = idInstr[15:11];
            shamt_d      = idInstr[10:6];
        end
        ill_cnt_d = ill_cnt_q;
        if (ill_inc && !(&ill_cnt_q))
            ill_cnt_d = ill_cnt_q + {{(ILL_CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            alu_op_q     <= 4'h0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            reg_dst_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            branch_q     <= 1'b0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_q        <= '0;
            rs_q         <= 5'd0;
            rt_q         <= 5'd0;
            rd_q         <= 5'd0;
            shamt_q      <= 5'd0;
            ill_cnt_q    <= '0;
        end else begin
            valid_q      <= valid_d;
            alu_op_q     <= alu_op_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            alu_src_q    <= alu_src_d;
            reg_dst_q    <= reg_dst_d;
            mem_to_reg_q <= mem_to_reg_d;
            branch_q     <= branch_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_q        <= imm_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            shamt_q      <= shamt_d;
            ill_cnt_q    <= ill_cnt_d;
        end
    end

    assign exValid      = valid_q;
    assign exAluOp      = alu_op_q;
    assign exRegWrite   = reg_write_q;
    assign exMemRead    = mem_read_q;
    assign exMemWrite   = mem_write_q;
    assign exAluSrc     = alu_src_q;
    assign exRegDst     = reg_dst_q;
    assign exMemToReg   = mem_to_reg_q;
    assign exBranch     = branch_q;
    assign exReadData1  = rd1_q;
    assign exReadData2  = rd2_q;
    assign exImm        = imm_q;
    assign exRs         = rs_q;
    assign exRt         = rt_q;
    assign exRd         = rd_q;
    assign exShamt      = shamt_q;
    assign illegalCount = ill_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode sweep, load-use stall, flush priority, immediates,
// illegal-count saturation and asynchronous reset during a stall.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        idValid;
    logic [31:0] idInstr;
    logic [31:0] idReadData1;
    logic [31:0] idReadData2;
    logic        flush;
    logic        stallOut;
    logic        exValid;
    logic [3:0]  exAluOp;
    logic        exRegWrite, exMemRead, exMemWrite, exAluSrc, exRegDst, exMemToReg, exBranch;
    logic [31:0] exReadData1, exReadData2, exImm;
    logic [4:0]  exRs, exRt, exRd, exShamt;
    logic [7:0]  illegalCount;

    int n_checks = 0;
    int n_errors = 0;

    id_ex_stage #(.DATA_W(32), .ILL_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .idValid(idValid), .idInstr(idInstr),
        .idReadData1(idReadData1), .idReadData2(idReadData2), .flush(flush),
        .stallOut(stallOut), .exValid(exValid), .exAluOp(exAluOp),
        .exRegWrite(exRegWrite), .exMemRead(exMemRead), .exMemWrite(exMemWrite),
        .exAluSrc(exAluSrc), .exRegDst(exRegDst), .exMemToReg(exMemToReg), .exBranch(exBranch),
        .exReadData1(exReadData1), .exReadData2(exReadData2), .exImm(exImm),
        .exRs(exRs), .exRt(exRt), .exRd(exRd), .exShamt(exShamt), .illegalCount(illegalCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [4:0] sh);
        return {6'h00, s, t, d, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                          input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    // Advance one rising edge and land 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] sweep_fn [11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
    logic [3:0] sweep_op [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hB, 4'h7, 4'h8, 4'h9};
    int exp_cnt;

    initial begin
        reset = 1'b1; idValid = 1'b0; idInstr = 32'h0; flush = 1'b0;
        idReadData1 = 32'h0; idReadData2 = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_exValid", {31'b0, exValid}, 32'h0);
        chk("rst_aluop", {28'b0, exAluOp}, 32'h0);
        chk("rst_illcnt", {24'b0, illegalCount}, 32'h0);
        chk("rst_stall", {31'b0, stallOut}, 32'h0);

        // R-type sweep
        idValid = 1'b1; idReadData1 = 32'h1111_2222; idReadData2 = 32'h3333_4444;
        for (int i = 0; i < 11; i++) begin
            idInstr = rtype(sweep_fn[i], 5'd1, 5'd2, 5'd3, 5'd4);
            tick();
            chk($sformatf("r_aluop_%0d", i), {28'b0, exAluOp}, {28'b0, sweep_op[i]});
            chk($sformatf("r_regdst_%0d", i), {31'b0, exRegDst}, 32'h1);
            chk($sformatf("r_valid_%0d", i), {31'b0, exValid}, 32'h1);
        end
        chk("r_regwrite", {31'b0, exRegWrite}, 32'h1);
        chk("r_alusrc", {31'b0, exAluSrc}, 32'h0);
        chk("r_rd", {27'b0, exRd}, 32'd3);
        chk("r_shamt", {27'b0, exShamt}, 32'd4);
        chk("r_rd1", exReadData1, 32'h1111_2222);
        chk("r_rd2", exReadData2, 32'h3333_4444);

        // Load-use: lw $8,4($1) then add $9,$8,$3
        idInstr = itype(6'h23, 5'd1, 5'd8, 16'h0004);
        tick();
        chk("lw_valid", {31'b0, exValid}, 32'h1);
        chk("lw_memread", {31'b0, exMemRead}, 32'h1);
        chk("lw_memtoreg", {31'b0, exMemToReg}, 32'h1);
        chk("lw_rt", {27'b0, exRt}, 32'd8);
        idInstr = rtype(6'h20, 5'd8, 5'd3, 5'd9, 5'd0);
        #1;
        chk("lu_stall", {31'b0, stallOut}, 32'h1);
        tick();
        chk("lu_bubble", {31'b0, exValid}, 32'h0);
        chk("lu_bubble_rw", {31'b0, exRegWrite}, 32'h0);
        chk("lu_stall_clear", {31'b0, stallOut}, 32'h0);
        tick();
        chk("lu_add_valid", {31'b0, exValid}, 32'h1);
        chk("lu_add_aluop", {28'b0, exAluOp}, 32'h0);
        chk("lu_add_rs", {27'b0, exRs}, 32'd8);

        // Flush overrides hazard
        idInstr = itype(6'h23, 5'd1, 5'd8, 16'h0004);
        tick();
        idInstr = rtype(6'h20, 5'd8, 5'd3, 5'd9, 5'd0);
        flush = 1'b1;
        #1;
        chk("fl_stall", {31'b0, stallOut}, 32'h0);
        tick();
        chk("fl_bubble", {31'b0, exValid}, 32'h0);
        chk("fl_illcnt", {24'b0, illegalCount}, 32'h0);
        flush = 1'b0;

        // Flushed illegal instruction does not count
        idInstr = itype(6'h3F, 5'd0, 5'd0, 16'h0);
        flush = 1'b1;
        tick();
        chk("fl_ill_cnt", {24'b0, illegalCount}, 32'h0);
        flush = 1'b0;

        // Illegal instruction during a stall does not count; counts once stall clears
        idInstr = itype(6'h23, 5'd1, 5'd8, 16'h0004);
        tick();
        idInstr = itype(6'h3F, 5'd8, 5'd0, 16'h0);
        #1;
        chk("ill_stall", {31'b0, stallOut}, 32'h1);
        tick();
        chk("ill_stall_cnt", {24'b0, illegalCount}, 32'h0);
        tick();
        chk("ill_cnt_1", {24'b0, illegalCount}, 32'h1);
        chk("ill_bubble", {31'b0, exValid}, 32'h0);

        // Immediates and I-type controls
        idInstr = itype(6'h0C, 5'd1, 5'd2, 16'h8000);
        tick();
        chk("andi_imm", exImm, 32'h0000_8000);
        chk("andi_aluop", {28'b0, exAluOp}, 32'h2);
        chk("andi_regdst", {31'b0, exRegDst}, 32'h0);
        idInstr = itype(6'h08, 5'd1, 5'd2, 16'h8000);
        tick();
        chk("addi_imm", exImm, 32'hFFFF_8000);
        chk("addi_aluop", {28'b0, exAluOp}, 32'h0);
        chk("addi_alusrc", {31'b0, exAluSrc}, 32'h1);
        idInstr = itype(6'h0F, 5'd0, 5'd2, 16'h1234);
        tick();
        chk("lui_aluop", {28'b0, exAluOp}, 32'hA);
        idInstr = itype(6'h2B, 5'd1, 5'd2, 16'hFFFC);
        tick();
        chk("sw_memwrite", {31'b0, exMemWrite}, 32'h1);
        chk("sw_regwrite", {31'b0, exRegWrite}, 32'h0);
        chk("sw_imm", exImm, 32'hFFFF_FFFC);
        idInstr = itype(6'h05, 5'd1, 5'd2, 16'h0010);
        tick();
        chk("bne_branch", {31'b0, exBranch}, 32'h1);
        chk("bne_aluop", {28'b0, exAluOp}, 32'h1);

        // Illegal saturation
        exp_cnt = 1;
        idInstr = itype(6'h3F, 5'd0, 5'd0, 16'h0);
        for (int c = 0; c < 300; c++) begin
            tick();
            if (exp_cnt < 255) exp_cnt++;
            chk("sat_valid", {31'b0, exValid}, 32'h0);
            chk("sat_cnt", {24'b0, illegalCount}, exp_cnt[31:0]);
        end
        chk("sat_final", {24'b0, illegalCount}, 32'd255);

        // Reset asserted mid-stall
        idInstr = itype(6'h23, 5'd1, 5'd8, 16'h0004);
        tick();
        idInstr = rtype(6'h20, 5'd3, 5'd8, 5'd9, 5'd0);
        #1;
        chk("mr_stall_pre", {31'b0, stallOut}, 32'h1);
        reset = 1'b1;
        #1;
        chk("mr_stall", {31'b0, stallOut}, 32'h0);
        chk("mr_valid", {31'b0, exValid}, 32'h0);
        chk("mr_memread", {31'b0, exMemRead}, 32'h0);
        chk("mr_rt", {27'b0, exRt}, 32'h0);
        chk("mr_imm", exImm, 32'h0);
        chk("mr_illcnt", {24'b0, illegalCount}, 32'h0);
        tick();
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute boundary of the 5-stage pipelined MIPS core.
- Decodes the ID-stage instruction into main control signals and the 4-bit ALU operation code that feeds the downstream ALU control block. Registers these, with operands, into the ID/EX pipeline register.
- Also detects load-use hazards: inserts a bubble and requests an IF/ID stall.
- Keeps a saturating count of illegal instructions.

Parameters:
- DATA_W, 32, operand/immediate width
- ILL_CNT_W, 8, illegal-instruction counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- idValid  in  1  ID-stage instruction is valid
- idInstr  in  32  instruction in ID
- idReadData1  in  DATA_W  register-file rs value
- idReadData2  in  DATA_W  register-file rt value
- flush  in  1  kill ID instruction (taken branch)
- stallOut  out  1  combinational; hold PC and IF/ID this cycle
- exValid  out  1  EX slot holds a real instruction
- exAluOp  out  4  ALU operation code to ALU control
- exRegWrite, exMemRead, exMemWrite, exAluSrc, exRegDst, exMemToReg, exBranch  out  1 each  registered control
- exReadData1, exReadData2  out  DATA_W  registered operands
- exImm  out  DATA_W  extended immediate
- exRs, exRt, exRd, exShamt  out  5 each  instruction fields
- illegalCount  out  ILL_CNT_W  saturating illegal-instruction count

Behaviour:
- Reset (asynchronous, active-high): every registered output is 0, including illegalCount. stallOut is then 0 because exValid=0.
- exAluOp encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOR
  - 0110 SLT, 0111 SLL, 1000 SRL, 1001 SRA, 1010 LUI, 1011 SLTU
  - 1100-1111 never produced
- R-type decode (opcode 0x00), by funct:
  - 20/21 ADD, 22/23 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR
  - 2A SLT, 2B SLTU, 00 SLL, 02 SRL, 03 SRA
  - Controls: RegDst=1, RegWrite=1, AluSrc=0.
- I-type decode, by opcode:
  - 08/09 ADD, 0C AND, 0D OR, 0E XOR, 0A SLT, 0B SLTU, 0F LUI
  - Controls: AluSrc=1, RegWrite=1, RegDst=0.
  - 23 lw: ADD, AluSrc=1, MemRead=1, MemToReg=1, RegWrite=1.
  - 2B sw: ADD, AluSrc=1, MemWrite=1.
  - 04 beq / 05 bne: SUB, Branch=1.
- Immediate extension: zero-extend for 0C/0D/0E; sign-extend otherwise.
- Illegal instruction: any other opcode or funct, with idValid=1.
  - Loads a bubble.
  - illegalCount increments by 1 per cycle, saturating at all-ones.
  - No increment during flush or stall.
- usesRt: 1 for R-type, sw, beq, bne.
- Hazard (combinational): exValid & exMemRead & exRt!=0 & idValid & (exRt==rs | (usesRt & exRt==rt)).
- stallOut = hazard & ~flush.
- Per-edge priority:
  - flush -> bubble
  - else hazard -> bubble
  - else idValid=0 or illegal -> bubble
  - else load decoded instruction with exValid=1
- Bubble: exValid=0; exAluOp and all control bits 0; data/field outputs don't-care (implementation zeroes them).
- Latency: one cycle from ID to EX outputs. No hold state: EX always advances each cycle.
- Stall is single-cycle by construction: the bubble clears exMemRead on the next edge.
- Reset mid-stall: stallOut drops immediately with reset (exValid=0 asynchronously).
- $zero writes: RegWrite stays as decoded; no special-casing here.

Test Plan:
- Reset mid-stream: assert reset with exValid=1 -> all outputs 0 asynchronously, before the next edge; illegalCount=0.
- R-type sweep: idValid=1, opcode 00, each funct in {20,22,24,25,26,27,2A,2B,00,02,03} -> next edge exAluOp = 0000,0001,0010,0011,0100,0101,0110,1011,0111,1000,1001 respectively; RegDst=1, exValid=1.
- Load-use: lw $8 then `add $9,$8,$3` -> cycle after lw: stallOut=1, EX gets bubble (exValid=0); next cycle add loads with exAluOp=0000, stallOut=0.
- Flush overrides hazard: same lw/add sequence with flush=1 in the hazard cycle -> stallOut=0, bubble, illegalCount unchanged.
- Immediates: `andi` imm 0x8000 -> exImm=0x00008000. `addi` imm 0x8000 -> exImm=0xFFFF8000, exAluOp=0000, AluSrc=1.
- Illegal saturation: opcode 0x3F held 300 cycles with ILL_CNT_W=8 -> exValid=0 throughout; illegalCount reaches 255 and holds.
